uart_rx_fsm: RTL and testbench
==============================

# uart_rx_fsm

Frame-sequencing controller for the UART receiver. It detects the start edge and enables and clears the shared `edge_bit_counter`. It then walks start/data/parity/stop bits from the counter's `bit_cnt`/`edge_cnt`, strobes the sampler, deserializer and checkers at mid-bit, and issues `data_valid` only for an error-free frame.

## Interface
Parameters:
- `PRESCALE_W`, default 6: width of `prescale` and `edge_cnt`.
- `BIT_CNT_W`, default 4: width of `bit_cnt`.

Ports:
- `CLK`, in, 1: oversampling clock.
- `RST`, in, 1: reset, asynchronous, active-low.
- `RX_IN`, in, 1: serial line, already synchronised; idle high.
- `PAR_EN`, in, 1: parity bit present.
- `prescale`, in, 6: oversampling ratio; legal values 8, 16, 32.
- `bit_cnt`, in, 4: from `edge_bit_counter`.
- `edge_cnt`, in, 6: from `edge_bit_counter`.
- `strt_glitch`, in, 1: start checker result, valid the cycle after `strt_chk_en`.
- `par_err`, in, 1: parity checker result, valid the cycle after `par_chk_en`.
- `stp_err`, in, 1: stop checker result, valid the cycle after `stp_chk_en`.
- `edge_bit_counter_en`, out, 1: counter enable.
- `cnt_clr`, out, 1: one-cycle synchronous clear request to the counter.
- `dat_samp_en`, out, 1: sampler enable.
- `deser_en`, out, 1: one-cycle deserializer shift strobe.
- `strt_chk_en`, out, 1: one-cycle start-check strobe.
- `par_chk_en`, out, 1: one-cycle parity-check strobe.
- `stp_chk_en`, out, 1: one-cycle stop-check strobe.
- `data_valid`, out, 1: one-cycle frame-good pulse.
- `par_error`, out, 1: sticky parity error for the last frame.
- `frame_error`, out, 1: sticky stop-bit error for the last frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- `PAR_EN` and `prescale` are latched on IDLE→START and held for the whole frame.
- Definitions: H = prescale/2 (shift, no divider); CHK = H+2; EVAL = H+3; LAST = prescale−1. All comparisons are at 6 bits.
- IDLE:
  - All enables are 0.
  - `RX_IN`==0 → START next cycle.
  - `par_error` and `frame_error` clear on this transition.
- START:
  - `edge_bit_counter_en`=1 and `dat_samp_en`=1 in every non-IDLE state.
  - `strt_chk_en` pulses at `edge_cnt`==CHK.
  - At EVAL, `strt_glitch`=1 → IDLE with a `cnt_clr` pulse.
  - At `edge_cnt`==LAST and `bit_cnt`==0 → DATA.
- DATA:
  - `deser_en` pulses at CHK for each of bits 1..8, giving 8 pulses total.
  - At LAST with `bit_cnt`==8 → PARITY if the latched PAR_EN=1, else STOP.
- PARITY:
  - `par_chk_en` pulses at CHK.
  - At EVAL, `par_err` is captured into `par_error`.
  - At LAST → STOP.
  - A parity error does not abort the frame.
- STOP:
  - `stp_chk_en` pulses at CHK.
  - At EVAL, `stp_err` is captured into `frame_error`.
  - The FSM then goes → IDLE next cycle with a `cnt_clr` pulse.
  - `data_valid`=1 on that same first IDLE cycle only if both `par_err`(captured) and `stp_err` are 0.
- Back-to-back frames: IDLE may re-detect `RX_IN`==0 on its first cycle. The counter is already cleared, because `cnt_clr` takes priority over enable in the counter.
- `RX_IN` is ignored outside IDLE, except through the checkers.

## Timing
- Reset values: state=IDLE and every output 0.
- Start-detect latency: falling `RX_IN` seen at cycle n → START at n+1, with `edge_cnt`=0 at n+1.
- Strobes are registered one-cycle pulses, asserted while `edge_cnt`==CHK is presented.
- `data_valid` rises exactly 2 cycles after the STOP-bit `stp_chk_en` pulse, and lasts 1 cycle.
- `par_error` and `frame_error` hold from capture until the next IDLE→START.
- Prescale 8: CHK=6, EVAL=7=LAST. The EVAL actions and the LAST transition occur in the same cycle, with the glitch abort taking priority.
- Reset mid-frame: everything returns to reset values immediately, with no `data_valid`. The counter is reset by the same `RST`.
- An illegal `prescale` is unsupported; the behaviour is undefined but the FSM must not lock up, because any state returns to IDLE on reset.

## Test plan
- Prescale 8, PAR_EN=0, byte 0xA5, valid stop → exactly 8 `deser_en` pulses, one `data_valid`, `par_error`=`frame_error`=0.
- Prescale 16, PAR_EN=1, byte 0x3C, parity checker forced to `par_err`=1 → no `data_valid`, `par_error`=1 held until the next start.
- Prescale 32, start low for 4 cycles then high → `strt_glitch`, return to IDLE, `cnt_clr` pulse, no `deser_en` pulses.
- Prescale 8, stop bit driven low → `frame_error`=1, no `data_valid`, back in IDLE.
- Two back-to-back frames 0x00 then 0xFF at prescale 16, next start immediately after stop → two `data_valid` pulses, second frame sees `edge_cnt` starting at 0.
- `RST` asserted during bit 4 of a frame → all outputs 0 next cycle; a following clean frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: start detect, bit walk,
// mid-bit strobes and frame-good / error reporting.
module uart_rx_fsm #(
   parameter int PRESCALE_W = 6,
   parameter int BIT_CNT_W  = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [BIT_CNT_W-1:0]  bit_cnt,
   input  logic [PRESCALE_W-1:0] edge_cnt,
   input  logic                  strt_glitch,
   input  logic                  par_err,
   input  logic                  stp_err,
   output logic                  edge_bit_counter_en,
   output logic                  cnt_clr,
   output logic                  dat_samp_en,
   output logic                  deser_en,
   output logic                  strt_chk_en,
   output logic                  par_chk_en,
   output logic                  stp_chk_en,
   output logic                  data_valid,
   output logic                  par_error,
   output logic                  frame_error
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t state;
   state_t state_n;

   logic [PRESCALE_W-1:0] presc_q;
   logic                  par_en_q;

   logic [PRESCALE_W-1:0] half;
   logic [PRESCALE_W-1:0] pre_chk;
   logic [PRESCALE_W-1:0] evl;
   logic [PRESCALE_W-1:0] lst;

   logic at_pre;
   logic at_evl;
   logic at_lst;
   logic in_data;

   logic cnt_clr_d;
   logic deser_d;
   logic strt_d;
   logic par_d;
   logic stp_d;
   logic data_valid_d;
   logic par_error_d;
   logic frame_error_d;

   // Decode points within a bit, from the prescale latched for this frame.
   // Strobes are registered, so they are decoded one edge before CHK.
   always_comb begin
      half    = {1'b0, presc_q[PRESCALE_W-1:1]};
      pre_chk = half + PRESCALE_W'(1);
      evl     = half + PRESCALE_W'(3);
      lst     = presc_q - PRESCALE_W'(1);
      at_pre  = (edge_cnt == pre_chk);
      at_evl  = (edge_cnt == evl);
      at_lst  = (edge_cnt == lst);
      in_data = (bit_cnt >= BIT_CNT_W'(1)) &&
                (bit_cnt <= BIT_CNT_W'(8));
   end

   // State, frame configuration and registered outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         presc_q     <= '0;
         par_en_q    <= 1'b0;
         cnt_clr     <= 1'b0;
         deser_en    <= 1'b0;
         strt_chk_en <= 1'b0;
         par_chk_en  <= 1'b0;
         stp_chk_en  <= 1'b0;
         data_valid  <= 1'b0;
         par_error   <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_n;
         if (state == IDLE && !RX_IN) begin
            presc_q  <= prescale;
            par_en_q <= PAR_EN;
         end
         cnt_clr     <= cnt_clr_d;
         deser_en    <= deser_d;
         strt_chk_en <= strt_d;
         par_chk_en  <= par_d;
         stp_chk_en  <= stp_d;
         data_valid  <= data_valid_d;
         par_error   <= par_error_d;
         frame_error <= frame_error_d;
      end
   end

   // Frame walk; a start glitch wins over the end-of-bit move.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (!RX_IN) state_n = START;
         end
         START: begin
            if (at_evl && strt_glitch)
               state_n = IDLE;
            else if (at_lst && bit_cnt == '0)
               state_n = DATA;
         end
         DATA: begin
            if (at_lst && bit_cnt == BIT_CNT_W'(8))
               state_n = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (at_lst) state_n = STOP;
         end
         STOP: begin
            if (at_evl) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Enables from state; next values of strobes, pulses and error flags.
   always_comb begin
      edge_bit_counter_en = (state != IDLE);
      dat_samp_en         = (state != IDLE);
      cnt_clr_d           = 1'b0;
      deser_d             = 1'b0;
      strt_d              = 1'b0;
      par_d               = 1'b0;
      stp_d               = 1'b0;
      data_valid_d        = 1'b0;
      par_error_d         = par_error;
      frame_error_d       = frame_error;
      unique case (state)
         IDLE: begin
            if (!RX_IN) begin
               par_error_d   = 1'b0;
               frame_error_d = 1'b0;
            end
         end
         START: begin
            strt_d = at_pre;
            if (at_evl && strt_glitch)
               cnt_clr_d = 1'b1;
         end
         DATA: begin
            deser_d = at_pre && in_data;
         end
         PARITY: begin
            par_d = at_pre;
            if (at_evl) par_error_d = par_err;
         end
         STOP: begin
            stp_d = at_pre;
            if (at_evl) begin
               frame_error_d = stp_err;
               cnt_clr_d     = 1'b1;
               data_valid_d  = !stp_err && !par_error;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with a counter, checker
// and deserializer model around it.
module tb_uart_rx_fsm;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic       PAR_EN = 1'b0;
   logic [5:0] prescale = 6'd8;
   logic [3:0] bit_cnt;
   logic [5:0] edge_cnt;
   logic       strt_glitch;
   logic       par_err;
   logic       stp_err;
   logic       edge_bit_counter_en;
   logic       cnt_clr;
   logic       dat_samp_en;
   logic       deser_en;
   logic       strt_chk_en;
   logic       par_chk_en;
   logic       stp_chk_en;
   logic       data_valid;
   logic       par_error;
   logic       frame_error;

   logic       force_par = 1'b0;
   logic [7:0] shreg;
   logic [9:0] outs;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int last_stp = 0;
   int n_deser = 0;
   int n_dv = 0;
   int n_clr = 0;
   int n_rise = 0;
   int n_pos = 0;
   int n_st0 = 0;
   int n_gap = 0;
   logic en_prev = 1'b0;
   logic [7:0] rx_q[$];

   always #5 CLK = ~CLK;

   uart_rx_fsm dut (
      .CLK                 (CLK),
      .RST                 (RST),
      .RX_IN               (RX_IN),
      .PAR_EN              (PAR_EN),
      .prescale            (prescale),
      .bit_cnt             (bit_cnt),
      .edge_cnt            (edge_cnt),
      .strt_glitch         (strt_glitch),
      .par_err             (par_err),
      .stp_err             (stp_err),
      .edge_bit_counter_en (edge_bit_counter_en),
      .cnt_clr             (cnt_clr),
      .dat_samp_en         (dat_samp_en),
      .deser_en            (deser_en),
      .strt_chk_en         (strt_chk_en),
      .par_chk_en          (par_chk_en),
      .stp_chk_en          (stp_chk_en),
      .data_valid          (data_valid),
      .par_error           (par_error),
      .frame_error         (frame_error)
   );

   assign outs = {edge_bit_counter_en, cnt_clr, dat_samp_en,
                  deser_en, strt_chk_en, par_chk_en, stp_chk_en,
                  data_valid, par_error, frame_error};

   // edge_bit_counter: clear beats enable, edge wraps at prescale-1
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (cnt_clr) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (edge_bit_counter_en) begin
         if (edge_cnt == prescale - 6'd1) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
         end else begin
            edge_cnt <= edge_cnt + 6'd1;
         end
      end
   end

   // checkers answer the cycle after their strobe; sampler/deserializer
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         strt_glitch <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
      end else begin
         strt_glitch <= strt_chk_en & RX_IN;
         par_err     <= par_chk_en & force_par;
         stp_err     <= stp_chk_en & ~RX_IN;
      end
   end

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (deser_en) shreg <= {RX_IN, shreg[7:1]};
   end

   // monitor on the falling edge
   always @(negedge CLK) begin
      en_prev <= edge_bit_counter_en;
      if (deser_en) n_deser <= n_deser + 1;
      if (cnt_clr) n_clr <= n_clr + 1;
      if (stp_chk_en) last_stp <= cyc;
      if (data_valid) begin
         n_dv <= n_dv + 1;
         rx_q.push_back(shreg);
         if (cyc - last_stp != 2) n_gap <= n_gap + 1;
      end
      if ((deser_en | strt_chk_en | par_chk_en | stp_chk_en) &&
          edge_cnt != (prescale >> 1) + 6'd2)
         n_pos <= n_pos + 1;
      if (edge_bit_counter_en && !en_prev) begin
         n_rise <= n_rise + 1;
         if (edge_cnt != 6'd0) n_st0 <= n_st0 + 1;
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input int n);
      RX_IN = v;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, input logic pe,
                       input logic stp, input int stop_len);
      int p;
      p = int'(prescale);
      drive(1'b0, p);
      for (int i = 0; i < 8; i++) drive(b[i], p);
      if (pe) drive(^b, p);
      drive(stp, stop_len);
   endtask

   function automatic logic [31:0] byte_at(input int idx);
      if (idx < rx_q.size()) return {24'd0, rx_q[idx]};
      return 32'hdead;
   endfunction

   int s_deser, s_dv, s_clr, s_rise, q0;

   initial begin
      #3;
      check("reset_outs", {22'd0, outs}, 32'd0);
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      drive(1'b1, 5);
      check("idle_outs", {22'd0, outs}, 32'd0);

      // prescale 8, no parity, 0xA5
      prescale = 6'd8;
      PAR_EN = 1'b0;
      s_deser = n_deser;
      s_dv = n_dv;
      q0 = rx_q.size();
      send(8'hA5, 1'b0, 1'b1, 8);
      drive(1'b1, 10);
      check("a_deser", n_deser - s_deser, 8);
      check("a_dv", n_dv - s_dv, 1);
      check("a_byte", byte_at(q0), 32'ha5);
      check("a_par", {31'd0, par_error}, 0);
      check("a_frm", {31'd0, frame_error}, 0);
      check("a_idle", {31'd0, edge_bit_counter_en}, 0);

      // prescale 16, parity forced bad, 0x3C
      prescale = 6'd16;
      PAR_EN = 1'b1;
      force_par = 1'b1;
      s_deser = n_deser;
      s_dv = n_dv;
      send(8'h3C, 1'b1, 1'b1, 16);
      drive(1'b1, 20);
      check("b_deser", n_deser - s_deser, 8);
      check("b_dv", n_dv - s_dv, 0);
      check("b_par", {31'd0, par_error}, 1);
      check("b_frm", {31'd0, frame_error}, 0);
      drive(1'b1, 30);
      check("b_par_hold", {31'd0, par_error}, 1);

      // prescale 32, 4-cycle start glitch
      prescale = 6'd32;
      PAR_EN = 1'b0;
      force_par = 1'b0;
      s_deser = n_deser;
      s_dv = n_dv;
      s_clr = n_clr;
      drive(1'b0, 4);
      drive(1'b1, 50);
      check("c_clr", n_clr - s_clr, 1);
      check("c_deser", n_deser - s_deser, 0);
      check("c_dv", n_dv - s_dv, 0);
      check("c_idle", {31'd0, edge_bit_counter_en}, 0);
      check("c_par_clr", {31'd0, par_error}, 0);

      // prescale 8, stop bit low
      prescale = 6'd8;
      s_dv = n_dv;
      send(8'h81, 1'b0, 1'b0, 8);
      drive(1'b1, 10);
      check("d_frm", {31'd0, frame_error}, 1);
      check("d_dv", n_dv - s_dv, 0);
      check("d_idle", {31'd0, edge_bit_counter_en}, 0);

      // prescale 16, back-to-back 0x00 then 0xFF
      prescale = 6'd16;
      s_dv = n_dv;
      s_rise = n_rise;
      q0 = rx_q.size();
      send(8'h00, 1'b0, 1'b1, 13);
      send(8'hFF, 1'b0, 1'b1, 16);
      drive(1'b1, 10);
      check("e_dv", n_dv - s_dv, 2);
      check("e_starts", n_rise - s_rise, 2);
      check("e_byte0", byte_at(q0), 32'h00);
      check("e_byte1", byte_at(q0 + 1), 32'hff);
      check("e_frm_clr", {31'd0, frame_error}, 0);

      // reset during data bit 4, then a clean frame
      s_dv = n_dv;
      drive(1'b0, 16);
      drive(1'b1, 56);
      RST = 1'b0;
      #1;
      check("f_rst_now", {22'd0, outs}, 32'd0);
      @(posedge CLK);
      #1;
      check("f_rst_cyc", {22'd0, outs}, 32'd0);
      check("f_rst_cnt", {26'd0, edge_cnt}, 0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      drive(1'b1, 5);
      check("f_no_dv", n_dv - s_dv, 0);
      s_deser = n_deser;
      s_dv = n_dv;
      q0 = rx_q.size();
      send(8'h96, 1'b0, 1'b1, 16);
      drive(1'b1, 10);
      check("f_deser", n_deser - s_deser, 8);
      check("f_dv", n_dv - s_dv, 1);
      check("f_byte", byte_at(q0), 32'h96);

      check("strobe_pos", n_pos, 0);
      check("start_edge0", n_st0, 0);
      check("dv_gap", n_gap, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
